apb_gpio_ctrl: RTL and testbench

- Parametrised APB4 GPIO slave; next generation of the single-instance GPIO hung off the APB master.
- Adds:
  - configurable pin count and wait states;
  - per-pin direction;
  - byte strobes;
  - input synchroniser;
  - per-pin rising/falling edge interrupts with W1C status;
  - address/access error reporting.
- Pad tristate (gpio_oe ? gpio_o : Z) lives in the top level, not in this block.

---
 rtl/apb_gpio_ctrl_pkg.sv | 35 +++
 rtl/apb_gpio_ctrl_sync_edge.sv | 40 ++++
 rtl/apb_gpio_ctrl.sv | 137 +++++++++++++
 tb/tb_apb_gpio_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_ctrl_pkg.sv
// Shared definitions for the APB GPIO slave: register offsets, bus FSM states
// and the byte-strobe merge helper used by every writable register.
package apb_gpio_pkg;

    localparam int APB_DW = 32;

    localparam logic [7:0] OFS_OUT      = 8'h00;
    localparam logic [7:0] OFS_DIR      = 8'h04;
    localparam logic [7:0] OFS_IN       = 8'h08;
    localparam logic [7:0] OFS_RISE_EN  = 8'h0C;
    localparam logic [7:0] OFS_FALL_EN  = 8'h10;
    localparam logic [7:0] OFS_IRQ_EN   = 8'h14;
    localparam logic [7:0] OFS_IRQ_STAT = 8'h18;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    function automatic logic [APB_DW-1:0] strb_mask(input logic [3:0] strb);
        logic [APB_DW-1:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

    // Old value keeps every byte lane whose strobe is low.
    function automatic logic [APB_DW-1:0] merge_strb(input logic [APB_DW-1:0] old,
                                                     input logic [APB_DW-1:0] wdata,
                                                     input logic [3:0]        strb);
        logic [APB_DW-1:0] mask;
        mask = strb_mask(strb);
        return (old & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/apb_gpio_ctrl_sync_edge.sv
// Multi-flop synchroniser for asynchronous pad inputs plus rising/falling edge
// detection on the synchronised value.
module gpio_sync_edge #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] chain [STAGES];
    logic [W-1:0] s;
    logic [W-1:0] s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
            s_d <= '0;
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            s_d <= s;
        end
    end

    assign s = chain[STAGES-1];
    // level is the delayed copy so IN changes on the same edge as IRQ_STAT.
    assign level = s_d;
    assign rise  = s & ~s_d;
    assign fall  = ~s & s_d;

endmodule

// File: rtl/apb_gpio_ctrl.sv
// APB4 GPIO slave: bus FSM with wait states, strobed register file, W1C edge
// interrupt status and error decode.
module apb_gpio_ctrl
    import apb_gpio_pkg::*;
#(
    parameter int GPIO_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    input  logic [3:0]        PSTRB,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq_o
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    apb_state_e        state, state_next;
    logic [2:0]        cnt, cnt_next;
    logic              ready, addr_err, wr_en, rd_en;
    logic [GPIO_W-1:0] out_q, dir_q, rise_en_q, fall_en_q, irq_en_q, irq_stat_q;
    logic [GPIO_W-1:0] in_sync, rise, fall, edge_set, w1c_clr;
    logic [APB_DW-1:0] rdata_raw;

    gpio_sync_edge #(.W(GPIO_W), .STAGES(SYNC_STAGES)) u_sync (
        .clk      (PCLK),
        .rst      (PRESET),
        .async_in (gpio_i),
        .level    (in_sync),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (PSEL && !PENABLE) state_next = SETUP;
            SETUP: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (PENABLE) begin
                    state_next = ACCESS;
                    cnt_next   = WAIT_INIT;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = (PSEL && !PENABLE) ? SETUP : IDLE;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready    = (state == ACCESS) && (cnt == '0);
    assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR > ADDR_W'(OFS_IRQ_STAT)) ||
                      (PWRITE && (PADDR == ADDR_W'(OFS_IN)));
    assign wr_en    = PSEL && PENABLE && ready && PWRITE && !addr_err;
    assign rd_en    = PSEL && PENABLE && ready && !PWRITE && !addr_err;

    assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign w1c_clr  = (wr_en && (PADDR == ADDR_W'(OFS_IRQ_STAT)))
                      ? GPIO_W'(PWDATA & strb_mask(PSTRB)) : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            out_q      <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
        end else begin
            if (wr_en) begin
                case (PADDR)
                    ADDR_W'(OFS_OUT):     out_q     <= GPIO_W'(merge_strb(APB_DW'(out_q), PWDATA, PSTRB));
                    ADDR_W'(OFS_DIR):     dir_q     <= GPIO_W'(merge_strb(APB_DW'(dir_q), PWDATA, PSTRB));
                    ADDR_W'(OFS_RISE_EN): rise_en_q <= GPIO_W'(merge_strb(APB_DW'(rise_en_q), PWDATA, PSTRB));
                    ADDR_W'(OFS_FALL_EN): fall_en_q <= GPIO_W'(merge_strb(APB_DW'(fall_en_q), PWDATA, PSTRB));
                    ADDR_W'(OFS_IRQ_EN):  irq_en_q  <= GPIO_W'(merge_strb(APB_DW'(irq_en_q), PWDATA, PSTRB));
                    default: ;
                endcase
            end
            // A new edge in the same cycle as a W1C clear must not be lost.
            irq_stat_q <= (irq_stat_q & ~w1c_clr) | edge_set;
        end
    end

    always_comb begin
        rdata_raw = '0;
        case (PADDR)
            ADDR_W'(OFS_OUT):      rdata_raw = APB_DW'(out_q);
            ADDR_W'(OFS_DIR):      rdata_raw = APB_DW'(dir_q);
            ADDR_W'(OFS_IN):       rdata_raw = APB_DW'(in_sync);
            ADDR_W'(OFS_RISE_EN):  rdata_raw = APB_DW'(rise_en_q);
            ADDR_W'(OFS_FALL_EN):  rdata_raw = APB_DW'(fall_en_q);
            ADDR_W'(OFS_IRQ_EN):   rdata_raw = APB_DW'(irq_en_q);
            ADDR_W'(OFS_IRQ_STAT): rdata_raw = APB_DW'(irq_stat_q);
            default:               rdata_raw = '0;
        endcase
    end

    assign PRDATA  = rd_en ? rdata_raw : '0;
    assign PREADY  = ready;
    assign PSLVERR = ready && addr_err;
    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign irq_o   = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Bench for apb_gpio_ctrl: a 32-pin/2-wait-state instance and an 8-pin/zero-wait
// instance on a shared APB bus, table-driven accesses plus timing sequences.
module tb_apb_gpio_ctrl;

    typedef struct {
        bit          to8;
        bit          write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0, psel8 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata, prdata8;
    logic        pready, pready8, pslverr, pslverr8;
    logic [31:0] gpio_i = '0;
    logic [31:0] gpio_o, gpio_oe;
    logic [7:0]  gpio_i8 = '0;
    logic [7:0]  gpio_o8, gpio_oe8;
    logic        irq, irq8;

    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vecs[$];
    logic [31:0] rd;
    bit          er;
    int          cyc;

    always #5 clk = ~clk;

    apb_gpio_ctrl #(.GPIO_W(32), .ADDR_W(8), .WAIT_STATES(2), .SYNC_STAGES(2)) u_dut (
        .PCLK(clk), .PRESET(preset), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq)
    );

    apb_gpio_ctrl #(.GPIO_W(8), .ADDR_W(8), .WAIT_STATES(0), .SYNC_STAGES(2)) u_dut8 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel8), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata8), .PREADY(pready8),
        .PSLVERR(pslverr8), .gpio_i(gpio_i8), .gpio_o(gpio_o8), .gpio_oe(gpio_oe8), .irq_o(irq8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the commit edge.
    task automatic apb(input bit to8, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output bit err, output int cycles);
        bit done;
        psel    = !to8;
        psel8   = to8;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        cycles  = 0;
        done    = 1'b0;
        while (!done && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if ((to8 ? pready8 : pready) === 1'b1) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL apb_timeout: addr 0x%02h got no PREADY within 20 cycles", addr);
        end
        rdata = to8 ? prdata8 : prdata;
        err   = to8 ? pslverr8 : pslverr;
        @(posedge clk); #1;
        psel    = 1'b0;
        psel8   = 1'b0;
        penable = 1'b0;
    endtask

    function automatic vec_t mk(bit to8, bit wr, logic [7:0] addr, logic [31:0] wdata,
                                logic [3:0] strb, logic [31:0] exp_rdata, bit exp_err);
        vec_t v;
        v.to8 = to8; v.write = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_ready;

        for (int a = 0; a <= 8'h18; a += 4) vecs.push_back(mk(0, 0, 8'(a), 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 8'h0C, 32'h0000_00F0, 4'hF, 32'h0, 0));
        vecs.push_back(mk(0, 0, 8'h0C, 32'h0,         4'h0, 32'h0000_00F0, 0));
        vecs.push_back(mk(0, 1, 8'h10, 32'h1234_5678, 4'h4, 32'h0, 0));
        vecs.push_back(mk(0, 0, 8'h10, 32'h0,         4'h0, 32'h0034_0000, 0));
        vecs.push_back(mk(0, 1, 8'h14, 32'hFFFF_FFFF, 4'h1, 32'h0, 0));
        vecs.push_back(mk(0, 0, 8'h14, 32'h0,         4'h0, 32'h0000_00FF, 0));
        vecs.push_back(mk(0, 0, 8'h1C, 32'h0,         4'h0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 8'h02, 32'h0,         4'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 8'h08, 32'hFFFF_FFFF, 4'hF, 32'h0, 1));
        vecs.push_back(mk(0, 0, 8'h08, 32'h0,         4'h0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 8'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1));
        vecs.push_back(mk(0, 1, 8'h01, 32'hFFFF_FFFF, 4'hF, 32'h0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0,         4'h0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0, 0));
        vecs.push_back(mk(1, 0, 8'h04, 32'h0,         4'h0, 32'h0000_00FF, 0));
        vecs.push_back(mk(1, 0, 8'h1C, 32'h0,         4'h0, 32'h0, 1));
        vecs.push_back(mk(1, 1, 8'h00, 32'h0000_0042, 4'h1, 32'h0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0,         4'h0, 32'h0000_0042, 0));

        repeat (3) @(posedge clk);
        #1 preset = 1'b0;
        check("reset_pready",  32'(pready),  32'h0);
        check("reset_pslverr", 32'(pslverr), 32'h0);
        check("reset_prdata",  prdata,       32'h0);
        check("reset_gpio_oe", gpio_oe,      32'h0);
        check("reset_gpio_o",  gpio_o,       32'h0);
        check("reset_irq",     32'(irq),     32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apb(vecs[i].to8, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, cyc);
            if (!vecs[i].write) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
        end
        check("gpio_oe8_after_dir", 32'(gpio_oe8), 32'h0000_00FF);

        // Strobed write with two wait states.
        apb(0, 1, 8'h00, 32'hFFFF_FFFF, 4'hF, rd, er, cyc);
        check("out_full_access_cycles", 32'(cyc), 32'd3);
        apb(0, 1, 8'h00, 32'hA5A5_5A5A, 4'b0011, rd, er, cyc);
        check("out_strb_access_cycles", 32'(cyc), 32'd3);
        check("out_strb_gpio_o", gpio_o, 32'hFFFF_5A5A);
        apb(0, 0, 8'h00, 32'h0, 4'h0, rd, er, cyc);
        check("out_strb_readback", rd, 32'hFFFF_5A5A);
        apb(0, 1, 8'h04, 32'h0000_FFFF, 4'hF, rd, er, cyc);
        check("dir_gpio_oe", gpio_oe, 32'h0000_FFFF);

        // Rising edge interrupt on pin 3 and its W1C clear.
        apb(0, 1, 8'h0C, 32'h0000_0009, 4'hF, rd, er, cyc);
        apb(0, 1, 8'h14, 32'h0000_0008, 4'hF, rd, er, cyc);
        gpio_i[3] = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("irq_before_latency", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("irq_after_latency", 32'(irq), 32'h1);
        apb(0, 0, 8'h18, 32'h0, 4'h0, rd, er, cyc);
        check("irq_stat_pin3", rd, 32'h0000_0008);
        apb(0, 0, 8'h08, 32'h0, 4'h0, rd, er, cyc);
        check("in_pin3", rd, 32'h0000_0008);
        apb(0, 1, 8'h18, 32'h0000_0008, 4'hF, rd, er, cyc);
        check("irq_after_w1c", 32'(irq), 32'h0);
        apb(0, 0, 8'h18, 32'h0, 4'h0, rd, er, cyc);
        check("irq_stat_after_w1c", rd, 32'h0);

        // Edge on pin 0 lands on the same edge as the W1C of bit 0.
        fork
            apb(0, 1, 8'h18, 32'h0000_0001, 4'hF, rd, er, cyc);
            begin
                repeat (2) @(posedge clk);
                #1 gpio_i[0] = 1'b1;
            end
        join
        apb(0, 0, 8'h18, 32'h0, 4'h0, rd, er, cyc);
        check("set_wins_over_w1c", rd, 32'h0000_0001);
        check("irq_masked_pin0", 32'(irq), 32'h0);
        apb(0, 1, 8'h18, 32'h0000_0001, 4'hF, rd, er, cyc);
        apb(0, 0, 8'h18, 32'h0, 4'h0, rd, er, cyc);
        check("w1c_pin0_alone", rd, 32'h0);

        // Reset asserted during the first ACCESS cycle of a write.
        psel = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h1234_5678; pstrb = 4'hF;
        penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 preset = 1'b1;
        @(posedge clk); #1 preset = 1'b0;
        any_ready = 1'b0;
        repeat (5) begin
            if (pready !== 1'b0) any_ready = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_pready", 32'(any_ready), 32'h0);
        check("abort_gpio_o", gpio_o, 32'h0);
        check("abort_gpio_oe", gpio_oe, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        apb(0, 0, 8'h00, 32'h0, 4'h0, rd, er, cyc);
        check("abort_out_readback", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
